// File: rtl/round_robin_arbiter_4_pkg.sv
// Shared constants and state encoding for the four-way round-robin arbiter.
package round_robin_arbiter_4_pkg;

  localparam int unsigned NumReq   = 4;
  localparam int unsigned IdxW     = 2;
  localparam int unsigned HoldCntW = 8;

  typedef enum logic {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } state_e;

endpackage

// File: rtl/two_to_four_decoder_gatelevel_module.sv
// Gate-level 2:4 decoder: b is the MSB, a the LSB of the selected output index.
module two_to_four_decoder_gatelevel_module (
  input  logic a,
  input  logic b,
  output logic out0,
  output logic out1,
  output logic out2,
  output logic out3
);

  logic na;
  logic nb;

  not u_not_a (na, a);
  not u_not_b (nb, b);

  and u_and_0 (out0, na, nb);
  and u_and_1 (out1, a,  nb);
  and u_and_2 (out2, na, b);
  and u_and_3 (out3, a,  b);

endmodule

// File: rtl/round_robin_arbiter_4.sv
// Four-requester round-robin arbiter with a bounded hold time and a one-hot grant vector.
// All outputs come from registered state; the only logic after the flops is the decoder and gate.
module round_robin_arbiter_4
  import round_robin_arbiter_4_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NumReq-1:0] req,
  output logic [NumReq-1:0] gnt,
  output logic              gnt_valid,
  output logic [IdxW-1:0]   gnt_idx,
  output logic              timeout
);

  localparam logic [HoldCntW-1:0] HoldLast = HoldCntW'(MAX_HOLD - 1);

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [IdxW-1:0]     ptr_q, ptr_d;
  logic [HoldCntW-1:0] hold_q, hold_d;
  logic                timeout_q, timeout_d;
  logic [NumReq-1:0]   dec;

  // First requester after the last owner, wrapping mod 4; the last owner itself is checked last.
  function automatic logic [IdxW-1:0] rr_pick(input logic [NumReq-1:0] r,
                                              input logic [IdxW-1:0]   p);
    logic [IdxW-1:0] idx;
    logic            found;
    rr_pick = p;
    found   = 1'b0;
    for (int k = 1; k <= NumReq; k++) begin
      idx = p + IdxW'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (|req) begin
          state_d = StGrant;
          idx_d   = rr_pick(req, ptr_q);
          ptr_d   = idx_d;
          hold_d  = '0;
        end
      end
      StGrant: begin
        hold_d = hold_q + 1'b1;
        // Voluntary release takes precedence over the hold limit.
        if (!req[idx_q]) begin
          state_d = StIdle;
        end else if (hold_q == HoldLast) begin
          state_d   = StIdle;
          timeout_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      ptr_q     <= IdxW'(NumReq - 1);
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  two_to_four_decoder_gatelevel_module u_dec (
    .a    (idx_q[0]),
    .b    (idx_q[1]),
    .out0 (dec[0]),
    .out1 (dec[1]),
    .out2 (dec[2]),
    .out3 (dec[3])
  );

  assign gnt_valid = (state_q == StGrant);
  assign gnt       = dec & {NumReq{gnt_valid}};
  assign gnt_idx   = idx_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_round_robin_arbiter_4.sv
// Directed bench for round_robin_arbiter_4 (MAX_HOLD = 4): each step queues the outputs
// expected after the next rising edge and checks them 1 ns after that edge.
module tb_round_robin_arbiter_4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'hF;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       to;
    string      tag;
  } exp_t;

  exp_t sb[$];

  round_robin_arbiter_4 #(
    .MAX_HOLD (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic [3:0] r, input logic rst, input logic [3:0] eg,
                     input logic [1:0] ei, input logic et, input string tag);
    exp_t e;
    req   = r;
    reset = rst;
    sb.push_back('{gnt: eg, idx: ei, to: et, tag: tag});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_checks++;
    assert (gnt === e.gnt) else begin
      n_fail++;
      $error("FAIL %s.gnt observed=%b expected=%b", e.tag, gnt, e.gnt);
    end
    n_checks++;
    assert (gnt_valid === (|e.gnt)) else begin
      n_fail++;
      $error("FAIL %s.gnt_valid observed=%b expected=%b", e.tag, gnt_valid, |e.gnt);
    end
    n_checks++;
    assert (gnt_idx === e.idx) else begin
      n_fail++;
      $error("FAIL %s.gnt_idx observed=%0d expected=%0d", e.tag, gnt_idx, e.idx);
    end
    n_checks++;
    assert (timeout === e.to) else begin
      n_fail++;
      $error("FAIL %s.timeout observed=%b expected=%b", e.tag, timeout, e.to);
    end
  endtask

  initial begin
    // Reset with all requests high: outputs stay at reset values.
    cyc(4'hF, 1'b1, 4'b0000, 2'd0, 1'b0, "rst0");
    cyc(4'hF, 1'b1, 4'b0000, 2'd0, 1'b0, "rst1");

    // Rotation: each owner holds 4 cycles, then one idle cycle carrying the timeout pulse.
    for (int o = 0; o < 4; o++) begin
      for (int c = 0; c < 4; c++) cyc(4'hF, 1'b0, 4'(1 << o), 2'(o), 1'b0, "rot_gnt");
      cyc(4'hF, 1'b0, 4'b0000, 2'(o), 1'b1, "rot_to");
    end
    cyc(4'hF, 1'b0, 4'b0001, 2'd0, 1'b0, "rot_wrap");
    cyc(4'h0, 1'b0, 4'b0000, 2'd0, 1'b0, "rot_drop");

    // Voluntary release after 3 granted cycles.
    cyc(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0, "vol_g1");
    cyc(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0, "vol_g2");
    cyc(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0, "vol_g3");
    cyc(4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, "vol_rel");
    cyc(4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, "vol_idle");

    // Last owner 2: req 1001 picks 3, then 0 after wrap.
    cyc(4'b1001, 1'b0, 4'b1000, 2'd3, 1'b0, "skip_g");
    cyc(4'b0001, 1'b0, 4'b0000, 2'd3, 1'b0, "skip_rel");
    cyc(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "wrap_g");

    // Owner drops req in its 4th granted cycle: no timeout.
    cyc(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "sim_g2");
    cyc(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "sim_g3");
    cyc(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "sim_g4");
    cyc(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "sim_rel");

    // Lone requester is re-granted the same index.
    cyc(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "regrant");
    cyc(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "regrant_rel");

    // Reset in cycle 2 of a grant to idx 1; pointer returns to 3 afterwards.
    cyc(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, "mid_g1");
    cyc(4'b0010, 1'b1, 4'b0000, 2'd0, 1'b0, "mid_rst");
    cyc(4'b0011, 1'b0, 4'b0001, 2'd0, 1'b0, "post_rst");

    n_checks++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/round_robin_arbiter_4.md
# round_robin_arbiter_4

Four-requester round-robin arbiter that shares one downstream resource among four clients and drives its one-hot select lines. A 2-bit registered grant index is expanded to a one-hot grant vector by the team's 2:4 decoder. The block holds a grant while the owner keeps requesting, bounded by a programmable maximum hold time, then rotates priority. It sits between request sources and any shared datapath whose select inputs are one-hot.

## Interface
- MAX_HOLD, 16, maximum consecutive cycles one requester may hold the grant; legal range 1..256.
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req  input  4  request vector; req[i] high means requester i wants the resource
- gnt  output  4  one-hot grant, all zero when idle
- gnt_valid  output  1  high while any grant is active (OR of gnt)
- gnt_idx  output  2  encoded index of current owner; holds last owner when idle
- timeout  output  1  one-cycle pulse when a grant is revoked by the MAX_HOLD limit

## Operation
- States: IDLE, GRANT. Registers: state, gnt_idx, ptr (last granted index, 2 bits), hold_cnt (8 bits).
- IDLE, req == 0: stay in IDLE, no register changes.
- IDLE, req != 0: winner = first i with req[i]=1, searching ptr+1, ptr+2, ptr+3, ptr+4 (mod 4). Next state GRANT; gnt_idx <= winner; ptr <= winner; hold_cnt <= 0.
- GRANT: hold_cnt increments by 1 each cycle.
  - req[gnt_idx] == 0: next state IDLE (voluntary release), timeout stays 0.
  - req[gnt_idx] == 1 and hold_cnt == MAX_HOLD-1: next state IDLE, timeout <= 1 for exactly one cycle.
  - otherwise stay in GRANT.
  - Both conditions true in the same cycle: voluntary release wins, so timeout = 0.
- Requests from non-owners during GRANT are ignored until the next IDLE cycle. Requests are level-sensitive and are not latched.
- gnt = decoder(gnt_idx) gated by (state == GRANT); gnt_valid = (state == GRANT).
- Wrap-around: ptr = 3 means the search order is 0,1,2,3. A lone requester always wins, including re-grant to the same index after release.
- Reset: state = IDLE, ptr = 3, gnt_idx = 0, hold_cnt = 0, timeout = 0. Outputs are therefore gnt = 0000, gnt_valid = 0, gnt_idx = 0, timeout = 0.

## Timing
- Grant latency: req sampled at edge N while in IDLE, so gnt is valid after edge N (visible from cycle N+1).
- Release latency: owner drops req in cycle M, so gnt returns to 0 after edge M. Every grant is followed by at least one IDLE cycle, so the minimum spacing between grants is 1 dead cycle.
- Maximum hold: a continuously requesting owner holds gnt for exactly MAX_HOLD cycles. The timeout pulse coincides with the first IDLE cycle.
- Worst-case wait for any continuously requesting client: 3 × (MAX_HOLD + 1) cycles.
- gnt, gnt_valid and gnt_idx are registered-state derived. The only combinational path is the decoder plus the AND gate; there is no combinational path from req to any output.
- Reset asserted mid-grant: after the next edge all outputs are at reset values, and any in-flight grant is dropped without a timeout pulse.

## Structure
- Shared package: state encoding constants (IDLE = 1'b0, GRANT = 1'b1), the requester-count constant 4, and the hold counter width 8.
- One sub-module, the existing two_to_four_decoder_gatelevel_module, instantiated once: gnt_idx[0] drives input a and gnt_idx[1] drives input b. Its out0..out3 outputs are ANDed with gnt_valid to form gnt[0..3].
- The priority search is a small combinational function inside the arbiter. It needs no separate module.

## Test plan
- Reset then idle: reset for 2 cycles with req = 1111 held → gnt = 0000, gnt_idx = 0, timeout = 0 during reset. The first grant after reset is gnt = 0001.
- Rotation: req = 1111 held, MAX_HOLD = 4 → grant sequence 0001, 0010, 0100, 1000, 0001. Each grant lasts 4 cycles with 1 idle cycle between, and timeout pulses after each grant.
- Voluntary release: req = 0100 for 3 cycles then 0000 → gnt = 0100 for 3 cycles starting one cycle after the request, then 0000, with no timeout.
- Wrap and skip: last owner 2, then req = 1001 → next grant is gnt = 1000 (idx 3). After release with req = 0001, the next grant is gnt = 0001.
- Simultaneous release and limit: MAX_HOLD = 4, owner drops req in its 4th granted cycle → gnt goes to 0 and timeout stays 0.
- Mid-grant reset: reset asserted in cycle 2 of a grant to idx 1 → all outputs at reset values after the edge. With req = 0011 after reset, the next grant is gnt = 0001 (ptr back to 3).
